// File: rtl/ex_result_stage.sv
// ex_result_stage: registered EX->MEM stage that applies RV64 word-op sign-extension and suppresses x0 writes.
// It uses a 2-entry skid buffer and exposes the head entry for operand forwarding.
module ex_result_stage #(
  parameter int XLEN    = 64,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_result,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic               in_reg_write,
  input  logic               in_word_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_result,
  output logic [RADDR_W-1:0] out_rd,
  output logic               out_reg_write,
  output logic               fwd_valid,
  output logic [RADDR_W-1:0] fwd_rd,
  output logic [XLEN-1:0]    fwd_data
);
  logic               main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]    main_result_q, main_result_d, skid_result_q, skid_result_d;
  logic [RADDR_W-1:0] main_rd_q, main_rd_d, skid_rd_q, skid_rd_d;
  logic               main_we_q, main_we_d, skid_we_q, skid_we_d;
  logic [XLEN-1:0]    new_result;
  logic               new_we, acc, rel, load_main, load_skid, shift;
  always_comb begin
    new_result = in_word_op ? {{(XLEN-32){in_result[31]}}, in_result[31:0]} : in_result;
    new_we     = in_reg_write & (in_rd != '0);
    acc        = in_valid & in_ready;
    rel        = main_valid_q & out_ready;
    load_main  = acc & (!main_valid_q | (rel & !skid_valid_q));
    load_skid  = acc & main_valid_q & !rel;
    shift      = rel & skid_valid_q;
    main_valid_d  = flush ? 1'b0 : (load_main | shift | (main_valid_q & !rel));
    skid_valid_d  = flush ? 1'b0 : (load_skid | (skid_valid_q & !rel));
    main_result_d = shift ? skid_result_q : load_main ? new_result : main_result_q;
    main_rd_d     = shift ? skid_rd_q : load_main ? in_rd : main_rd_q;
    main_we_d     = shift ? skid_we_q : load_main ? new_we : main_we_q;
    skid_result_d = load_skid ? new_result : skid_result_q;
    skid_rd_d     = load_skid ? in_rd : skid_rd_q;
    skid_we_d     = load_skid ? new_we : skid_we_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q  <= 1'b0;
      skid_valid_q  <= 1'b0;
      main_result_q <= '0;
      main_rd_q     <= '0;
      main_we_q     <= 1'b0;
      skid_result_q <= '0;
      skid_rd_q     <= '0;
      skid_we_q     <= 1'b0;
    end else begin
      main_valid_q  <= main_valid_d;
      skid_valid_q  <= skid_valid_d;
      main_result_q <= main_result_d;
      main_rd_q     <= main_rd_d;
      main_we_q     <= main_we_d;
      skid_result_q <= skid_result_d;
      skid_rd_q     <= skid_rd_d;
      skid_we_q     <= skid_we_d;
    end
  end
  assign in_ready      = !skid_valid_q;
  assign out_valid     = main_valid_q;
  assign out_result    = main_result_q;
  assign out_rd        = main_rd_q;
  assign out_reg_write = main_we_q;
  assign fwd_valid     = main_valid_q & main_we_q;
  assign fwd_rd        = main_rd_q;
  assign fwd_data      = main_result_q;
endmodule

// File: tb/tb_ex_result_stage.sv
// tb_ex_result_stage: vector table plus scoreboard bench for ex_result_stage.
module tb_ex_result_stage;
  logic        clk = 0, rst = 1, flush = 0, in_valid = 0, in_reg_write = 0, in_word_op = 0, out_ready = 0;
  logic [63:0] in_result = 0;
  logic [4:0]  in_rd = 0;
  logic        in_ready, out_valid, out_reg_write, fwd_valid;
  logic [63:0] out_result, fwd_data;
  logic [4:0]  out_rd, fwd_rd;
  int checks = 0, failures = 0, pops = 0;

  typedef struct {logic [63:0] res; logic [4:0] rd; logic we;} ent_t;
  typedef struct {logic [63:0] res; logic [4:0] rd; logic we; logic wo; logic [63:0] exp_res; logic exp_we;} vec_t;
  ent_t q[$];
  vec_t vecs[5];

  ex_result_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_rd(in_rd), .in_reg_write(in_reg_write), .in_word_op(in_word_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic ent_t model(logic [63:0] r, logic [4:0] rd, logic we, logic wo);
    ent_t e;
    e.res = wo ? {{32{r[31]}}, r[31:0]} : r;
    e.rd  = rd;
    e.we  = we && rd != 0;
    return e;
  endfunction

  // Handshakes are sampled just before the rising edge that acts on them.
  always @(negedge clk) begin
    ent_t e;
    #4;
    if (rst) q.delete();
    else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb_unexpected: got result %h with no entry expected", out_result);
        end else begin
          e = q.pop_front();
          pops++;
          chk("sb_result", out_result, e.res);
          chk("sb_rd", 64'(out_rd), 64'(e.rd));
          chk("sb_we", 64'(out_reg_write), 64'(e.we));
        end
      end
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back(model(in_result, in_rd, in_reg_write, in_word_op));
    end
  end

  task automatic drive(input logic v, input logic [63:0] r, input logic [4:0] rd, input logic we, input logic wo);
    in_valid = v; in_result = r; in_rd = rd; in_reg_write = we; in_word_op = wo;
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 0);
    chk({tag, "_in_ready"}, 64'(in_ready), 1);
    chk({tag, "_fwd_valid"}, 64'(fwd_valid), 0);
  endtask

  initial begin
    int p0;
    vecs[0] = '{64'h5, 5'd3, 1'b1, 1'b0, 64'h5, 1'b1};
    vecs[1] = '{64'h1234_5678_8000_0001, 5'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_8000_0001, 1'b1};
    vecs[2] = '{64'hFFFF_FFFF_7FFF_FFFF, 5'd9, 1'b1, 1'b1, 64'h0000_0000_7FFF_FFFF, 1'b1};
    vecs[3] = '{64'hDEAD, 5'd0, 1'b1, 1'b0, 64'hDEAD, 1'b0};
    vecs[4] = '{64'h0000_0001_0000_ABCD, 5'd4, 1'b0, 1'b1, 64'h0000_0000_0000_ABCD, 1'b0};
    repeat (2) @(negedge clk);
    chk_empty("reset");
    chk("reset_out_result", out_result, 0);
    chk("reset_out_rd", 64'(out_rd), 0);
    chk("reset_out_we", 64'(out_reg_write), 0);
    rst = 0;
    out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(1, vecs[i].res, vecs[i].rd, vecs[i].we, vecs[i].wo);
      @(negedge clk);
      drive(0, 0, 0, 0, 0);
      chk("vec_out_valid", 64'(out_valid), 1);
      chk("vec_out_result", out_result, vecs[i].exp_res);
      chk("vec_out_rd", 64'(out_rd), 64'(vecs[i].rd));
      chk("vec_out_we", 64'(out_reg_write), 64'(vecs[i].exp_we));
      chk("vec_fwd_valid", 64'(fwd_valid), 64'(vecs[i].exp_we));
      chk("vec_fwd_data", fwd_data, vecs[i].exp_res);
      chk("vec_fwd_rd", 64'(fwd_rd), 64'(vecs[i].rd));
    end
    // Backpressure: A in main, B in skid, C held upstream.
    @(negedge clk);
    out_ready = 0;
    drive(1, 64'd1, 5'd1, 1, 0);
    @(negedge clk);
    drive(1, 64'd2, 5'd2, 1, 0);
    chk("bp_a_main", out_result, 1);
    chk("bp_ready_after_a", 64'(in_ready), 1);
    @(negedge clk);
    drive(1, 64'd3, 5'd3, 1, 0);
    chk("bp_ready_full", 64'(in_ready), 0);
    repeat (2) begin
      @(negedge clk);
      chk("bp_hold_result", out_result, 1);
      chk("bp_hold_valid", 64'(out_valid), 1);
      chk("bp_hold_ready", 64'(in_ready), 0);
    end
    out_ready = 1;
    @(negedge clk);
    chk("bp_out_b", out_result, 2);
    chk("bp_ready_back", 64'(in_ready), 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    chk("bp_out_c", out_result, 3);
    @(negedge clk);
    chk("bp_drained", 64'(out_valid), 0);
    // Full throughput: 16 back-to-back entries.
    p0 = pops;
    for (int i = 0; i < 16; i++) begin
      drive(1, {$urandom, $urandom}, 5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom));
      @(negedge clk);
      chk("tp_ready", 64'(in_ready), 1);
      chk("tp_valid", 64'(out_valid), 1);
    end
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("tp_pops", 64'(pops - p0), 16);
    // Flush with main and skid full and a new input offered.
    out_ready = 0;
    drive(1, 64'hAA, 5'd10, 1, 0);
    @(negedge clk);
    drive(1, 64'hBB, 5'd11, 1, 0);
    @(negedge clk);
    drive(1, 64'hCC, 5'd12, 1, 0);
    flush = 1;
    chk("fl_pre_full", 64'(in_ready), 0);
    @(negedge clk);
    flush = 0;
    drive(0, 0, 0, 0, 0);
    chk_empty("flush");
    out_ready = 1;
    repeat (3) begin
      @(negedge clk);
      chk("flush_no_stale", 64'(out_valid), 0);
    end
    // Reset mid-stream.
    out_ready = 0;
    drive(1, 64'h11, 5'd13, 1, 0);
    @(negedge clk);
    drive(1, 64'h22, 5'd14, 1, 0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    drive(0, 0, 0, 0, 0);
    chk_empty("rst_mid");
    chk("rst_mid_result", out_result, 0);
    chk("rst_mid_rd", 64'(out_rd), 0);
    chk("rst_mid_we", 64'(out_reg_write), 0);
    out_ready = 1;
    repeat (3) @(negedge clk);
    chk("sb_leftover", 64'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
